// File: rtl/memory_sub_system_param.sv
// Shared geometry, types and helpers for the 1 kB direct-mapped cache and its
// 64 kB backing memory.
package memory_sub_system_param;

    localparam int unsigned ADDR_LENGTH     = 16;
    localparam int unsigned WORD_SIZE       = 32;
    localparam int unsigned CACHE_LINE_SIZE = 16;
    localparam int unsigned NUM_CACHE_LINES = 64;
    localparam int unsigned OFFSET_LENGTH   = 4;
    localparam int unsigned INDEX_LENGTH    = 6;
    localparam int unsigned TAG_LENGTH      = ADDR_LENGTH - INDEX_LENGTH - OFFSET_LENGTH;
    localparam int unsigned LINE_BITS       = CACHE_LINE_SIZE * 8;

    typedef logic [TAG_LENGTH-1:0]    tag_t;
    typedef logic [INDEX_LENGTH-1:0]  index_t;
    typedef logic [OFFSET_LENGTH-1:0] offset_t;
    typedef logic [LINE_BITS-1:0]     line_t;
    typedef logic [WORD_SIZE-1:0]     word_t;

    typedef struct packed {
        tag_t    tag;
        index_t  index;
        offset_t offset;
    } addr_fields_t;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWbReq,
        StFillReq,
        StFillWait
    } cache_state_e;

    function automatic logic [ADDR_LENGTH-1:0] line_addr(input tag_t tag, input index_t index);
        addr_fields_t f;
        f.tag    = tag;
        f.index  = index;
        f.offset = '0;
        return f;
    endfunction

endpackage

// File: rtl/dm_cache_store.sv
// Tag/valid/dirty/data arrays: one combinational read port and one registered write
// port shared by line fill, word merge and dirty clear.
module dm_cache_store
    import memory_sub_system_param::*;
#(
    parameter int unsigned N_LINES = NUM_CACHE_LINES,
    parameter int unsigned IDX_W   = INDEX_LENGTH,
    parameter int unsigned TAG_W   = TAG_LENGTH,
    parameter int unsigned LINE_W  = LINE_BITS,
    parameter int unsigned WORD_W  = WORD_SIZE,
    parameter int unsigned SEL_W   = $clog2(LINE_W / WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              word_en,
    input  logic [SEL_W-1:0]  word_sel,
    input  logic [WORD_W-1:0] word_data,
    input  logic              clr_dirty
);

    logic [N_LINES-1:0] valid_q;
    logic [N_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]   tag_q  [N_LINES];
    logic [LINE_W-1:0]  data_q [N_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_en) begin
            dirty_q[idx] <= 1'b1;
        end else if (clr_dirty) begin
            dirty_q[idx] <= 1'b0;
        end
    end

    // Tag and data storage carry no reset; valid_q guards every read.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_line;
        end else if (word_en) begin
            data_q[idx][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller: request FSM, miss
// handling toward main memory, and saturating hit/miss counters.
module dm_cache_ctrl
    import memory_sub_system_param::*;
#(
    parameter int unsigned ADDR_W  = ADDR_LENGTH,
    parameter int unsigned WORD_W  = WORD_SIZE,
    parameter int unsigned LINE_W  = LINE_BITS,
    parameter int unsigned N_LINES = NUM_CACHE_LINES,
    parameter int unsigned IDX_W   = INDEX_LENGTH,
    parameter int unsigned TAG_W   = TAG_LENGTH,
    parameter int unsigned OFF_W   = OFFSET_LENGTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [WORD_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [WORD_W-1:0] cpu_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_rdata,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int unsigned SEL_W = OFF_W - 2;

    cache_state_e state_q, state_d;

    logic              ready_en_q;
    logic              req_we_q;
    tag_t              req_tag_q;
    index_t            req_idx_q;
    logic [SEL_W-1:0]  req_sel_q;
    logic [WORD_W-1:0] req_wdata_q;
    logic              retry_q;
    logic              resp_valid_q;
    logic [WORD_W-1:0] resp_rdata_q;
    logic [15:0]       hit_cnt_q;
    logic [15:0]       miss_cnt_q;

    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              wr_fill;
    logic              wr_word;
    logic              clr_dirty;
    logic              hit;
    logic              accept;
    addr_fields_t      cpu_f;
    logic [1:0]        unused_byte;

    assign cpu_f       = cpu_req_addr;
    assign unused_byte = cpu_f.offset[1:0];
    assign hit         = rd_valid && (rd_tag == req_tag_q);
    assign accept      = cpu_req_valid && cpu_req_ready;

    dm_cache_store #(
        .N_LINES (N_LINES),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W),
        .LINE_W  (LINE_W),
        .WORD_W  (WORD_W),
        .SEL_W   (SEL_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (req_idx_q),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .fill_en   (wr_fill),
        .fill_tag  (req_tag_q),
        .fill_line (mem_resp_rdata),
        .word_en   (wr_word),
        .word_sel  (req_sel_q),
        .word_data (req_wdata_q),
        .clr_dirty (clr_dirty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StCompare;
            end
            StCompare: begin
                if (hit)                       state_d = StIdle;
                else if (rd_valid && rd_dirty) state_d = StWbReq;
                else                           state_d = StFillReq;
            end
            StWbReq: begin
                if (mem_req_ready) state_d = StFillReq;
            end
            StFillReq: begin
                if (mem_req_ready) state_d = StFillWait;
            end
            StFillWait: begin
                if (mem_resp_valid) state_d = StCompare;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cpu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        wr_fill       = 1'b0;
        wr_word       = 1'b0;
        clr_dirty     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cpu_req_ready = ready_en_q;
            end
            StCompare: begin
                wr_word = hit && req_we_q;
            end
            StWbReq: begin
                // Array contents are frozen in this state, so the request stays stable.
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = line_addr(rd_tag, req_idx_q);
                mem_req_wdata = rd_line;
                clr_dirty     = mem_req_ready;
            end
            StFillReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = line_addr(req_tag_q, req_idx_q);
            end
            StFillWait: begin
                wr_fill = mem_resp_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q   <= 1'b0;
            req_we_q     <= 1'b0;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_sel_q    <= '0;
            req_wdata_q  <= '0;
            retry_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            ready_en_q   <= 1'b1;
            resp_valid_q <= 1'b0;
            if (accept) begin
                req_we_q    <= cpu_req_we;
                req_tag_q   <= cpu_f.tag;
                req_idx_q   <= cpu_f.index;
                req_sel_q   <= cpu_f.offset[OFF_W-1:2];
                req_wdata_q <= cpu_req_wdata;
                retry_q     <= 1'b0;
            end
            // The post-fill retry hits by construction and must not count as a hit.
            if (wr_fill) retry_q <= 1'b1;
            if (state_q == StCompare) begin
                if (hit) begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= req_we_q ? req_wdata_q
                                             : rd_line[req_sel_q*WORD_W +: WORD_W];
                    if (!retry_q && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
                end else if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end
        end
    end

    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;

endmodule
